uart_periph: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_core.sv | 86 ++++++++
 rtl/uart_periph.sv | 149 ++++++++++++++
 tb/tb_uart_periph.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and baud divisor helper for the UART peripheral.
package uart_pkg;
  localparam logic [23:0] BASE_HI = 24'h400000;
  localparam logic [7:0]  TXD_OFF = 8'h18;
  localparam logic [7:0]  RXD_OFF = 8'h1C;
  localparam logic [7:0]  CON_OFF = 8'h20;

  localparam int CON_TX_IE    = 0;
  localparam int CON_RX_IE    = 1;
  localparam int CON_TX_DONE  = 2;
  localparam int CON_RX_READY = 3;
  localparam int CON_TX_BUSY  = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchroniser, oversample counter and RX FSM; emits byte with valid/frame_err pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  input  logic       tick16_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);
  localparam int OS_W = $clog2(OVERSAMPLE);

  rx_state_t       state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [OS_W-1:0] os_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            fall, mid_start, full_bit;

  assign fall      = prev_q & ~sync2_q;
  assign mid_start = tick16_i && (os_q == OS_W'(OVERSAMPLE/2 - 1));
  assign full_bit  = tick16_i && (os_q == OS_W'(OVERSAMPLE - 1));

  // Synchroniser flops reset to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (mid_start) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_bit && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (full_bit) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_o      = shift_q;
    valid_o     = (state_q == RX_STOP) && full_bit && sync2_q;
    frame_err_o = (state_q == RX_STOP) && full_bit && !sync2_q;
  end

  // Counter restarts at mid-start so later samples land mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          os_q  <= '0;
          bit_q <= '0;
        end
        RX_START: begin
          if (mid_start)     os_q <= '0;
          else if (tick16_i) os_q <= os_q + 1'b1;
        end
        default: begin
          if (tick16_i) os_q <= os_q + 1'b1;
          if (state_q == RX_DATA && full_bit) begin
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART: bus decode, register file, baud divider and TX FSM; RX lives in uart_rx_core.
module uart_periph
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  logic             sel_txd, sel_rxd, sel_con, wr_txd, wr_con, rd_rxd, rd_con;
  logic [DIV_W-1:0] div_q;
  logic             tick16, bit_tick, tx_busy, tx_fin;
  tx_state_t        tx_state_q, tx_state_d;
  logic [OS_W-1:0]  tx_os_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_byte_q, rxd_q, rx_byte;
  logic             tx_q, tx_d;
  logic [1:0]       ie_q;
  logic             tx_done_q, rx_ready_q, irq_q, rx_vld, rx_ferr;
  logic [31:0]      con_val;
  logic             unused_bits;

  assign sel_txd = (addr[31:8] == BASE_HI) && (addr[7:0] == TXD_OFF);
  assign sel_rxd = (addr[31:8] == BASE_HI) && (addr[7:0] == RXD_OFF);
  assign sel_con = (addr[31:8] == BASE_HI) && (addr[7:0] == CON_OFF);
  assign wr_txd  = mem_write & sel_txd;
  assign wr_con  = mem_write & sel_con;
  assign rd_rxd  = mem_read & sel_rxd;
  assign rd_con  = mem_read & sel_con;

  assign tick16   = (div_q == DIV_W'(DIV - 1));
  assign bit_tick = tick16 && (tx_os_q == OS_W'(OVERSAMPLE - 1));
  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign tx_fin   = (tx_state_q == TX_STOP) && bit_tick;

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= tick16 ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (wr_txd) tx_state_d = TX_START;
      TX_START: if (bit_tick) tx_state_d = TX_DATA;
      TX_DATA:  if (bit_tick && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      TX_STOP:  if (bit_tick) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (tx_state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_byte_q[tx_bit_q];
      default:  tx_d = 1'b1;
    endcase
  end

  // Bit timer restarts on every frame; only the byte latch is gated by IDLE, so busy writes drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_os_q   <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
    end else if (tx_state_q == TX_IDLE) begin
      tx_os_q  <= '0;
      tx_bit_q <= '0;
      if (wr_txd) tx_byte_q <= wdata[7:0];
    end else begin
      if (tick16) tx_os_q <= tx_os_q + 1'b1;
      if (tx_state_q == TX_DATA && bit_tick) tx_bit_q <= tx_bit_q + 1'b1;
    end
  end

  uart_rx_core #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (uart_rx),
    .tick16_i   (tick16),
    .byte_o     (rx_byte),
    .valid_o    (rx_vld),
    .frame_err_o(rx_ferr)
  );

  // Flag set beats a same-cycle read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q       <= '0;
      tx_done_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      rxd_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_con) ie_q <= wdata[1:0];
      if (tx_fin)      tx_done_q <= 1'b1;
      else if (rd_con) tx_done_q <= 1'b0;
      if (rx_vld) begin
        rx_ready_q <= 1'b1;
        rxd_q      <= rx_byte;
      end else if (rd_rxd) begin
        rx_ready_q <= 1'b0;
      end
      irq_q <= (ie_q[0] & tx_done_q) | (ie_q[1] & rx_ready_q);
    end
  end

  always_comb begin
    con_val               = '0;
    con_val[CON_TX_IE]    = ie_q[0];
    con_val[CON_RX_IE]    = ie_q[1];
    con_val[CON_TX_DONE]  = tx_done_q;
    con_val[CON_RX_READY] = rx_ready_q;
    con_val[CON_TX_BUSY]  = tx_busy;
    rdata = '0;
    if (sel_txd)      rdata = {24'b0, tx_byte_q};
    else if (sel_rxd) rdata = {24'b0, rxd_q};
    else if (sel_con) rdata = con_val;
  end

  assign unused_bits = ^{wdata[31:8], rx_ferr};
  assign irq         = irq_q;
  assign uart_tx     = tx_q;
endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph at a scaled clock: DIV=4, 16x oversample, 64 clocks per bit.
`timescale 1ns/1ps
module tb_uart_periph;
  import uart_pkg::*;
  localparam int CLK_FREQ = 614400;
  localparam int BAUD     = 9600;
  localparam int OS       = 16;
  localparam int BIT      = 64;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        mem_write = 1'b0, mem_read = 1'b0, irq, uart_rx = 1'b1, uart_tx;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_periph #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_write(mem_write),
    .mem_read(mem_read), .rdata(rdata), .irq(irq), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; mem_read = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    mem_read = 1'b0; addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // Samples each bit mid-way from the start edge and checks TX_BUSY alongside it.
  task automatic check_tx_frame(input logic [7:0] b, input string name);
    logic [9:0]  exp;
    logic [31:0] d;
    int          n;
    exp = {1'b1, b, 1'b0};
    n = 0;
    while (uart_tx !== 1'b0 && n < 4 * BIT) begin
      @(negedge clk); n++;
    end
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start_edge timeout: uart_tx=%b required 0", name, uart_tx);
      return;
    end
    repeat (BIT / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (uart_tx !== exp[k]) begin
        errors++;
        $display("FAIL %s bit%0d: got %b required %b", name, k, uart_tx, exp[k]);
      end
      bus_read(A_CON, d);
      checks++;
      if (d[CON_TX_BUSY] !== 1'b1) begin
        errors++;
        $display("FAIL %s busy@bit%0d: got %b required 1", name, k, d[CON_TX_BUSY]);
      end
      if (k < 9) repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", uart_tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
    bus_read(A_CON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_con: got %h required 0", d); end
    bus_read(A_RXD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rxd: got %h required 0", d); end
  endtask

  task automatic test_div_and_decode();
    logic [31:0] d;
    int          v;
    v = calc_div(100000000, 9600, 16);
    checks++; if (v !== 651) begin errors++; $display("FAIL div_default: got %0d required 651", v); end
    bus_write(32'h4000_0024, 32'h3);
    bus_write(32'h5000_0020, 32'h3);
    bus_read(A_CON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL undecoded_write: got %h required 0", d); end
    bus_read(32'h4000_0024, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL undecoded_read: got %h required 0", d); end
  endtask

  task automatic test_transmit();
    logic [31:0] d;
    bus_write(A_CON, 32'h3);
    bus_write(A_TXD, 32'hFFFF_FFA5);
    check_tx_frame(8'hA5, "tx_a5");
    repeat (BIT) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq: got %b required 1", irq); end
    bus_read(A_CON, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL tx_con_done: got %h required 7", d); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tx_irq_clear: got %b required 0", irq); end
    bus_read(A_CON, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL tx_con_after: got %h required 3", d); end
    bus_read(A_TXD, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL txd_readback: got %h required a5", d); end
  endtask

  task automatic test_receive();
    logic [31:0] d;
    send_rx(8'h3C, 1'b1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b required 1", irq); end
    bus_read(A_CON, d);
    checks++; if (d !== 32'hB) begin errors++; $display("FAIL rx_con_ready: got %h required b", d); end
    bus_read(A_RXD, d);
    checks++; if (d !== 32'h3C) begin errors++; $display("FAIL rx_data: got %h required 3c", d); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: got %b required 0", irq); end
    bus_read(A_CON, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL rx_con_after: got %h required 3", d); end
  endtask

  task automatic test_false_start();
    logic [31:0] d;
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    bus_read(A_CON, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL false_start_con: got %h required 3", d); end
  endtask

  task automatic test_framing();
    logic [31:0] d;
    send_rx(8'h5A, 1'b0);
    bus_read(A_CON, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL frame_err_con: got %h required 3", d); end
    bus_read(A_RXD, d);
    checks++; if (d !== 32'h3C) begin errors++; $display("FAIL frame_err_rxd: got %h required 3c", d); end
  endtask

  task automatic test_busy_write();
    logic [31:0] d;
    bus_write(A_TXD, 32'hC3);
    repeat (3) @(negedge clk);
    bus_write(A_TXD, 32'h18);
    check_tx_frame(8'hC3, "tx_busy_write");
    bus_read(A_TXD, d);
    checks++; if (d !== 32'hC3) begin errors++; $display("FAIL busy_txd: got %h required c3", d); end
    repeat (BIT) @(negedge clk);
    bus_read(A_CON, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL busy_con_done: got %h required 7", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d, seen;
    logic        found;
    int          n;
    send_rx(8'h3C, 1'b1);
    found = 1'b0;
    seen  = '0;
    fork
      send_rx(8'h81, 1'b1);
      begin
        n = 0;
        while (!found && n < 12 * BIT) begin
          if (dut.rx_vld === 1'b1) begin
            addr = A_RXD; mem_read = 1'b1;
            #1 seen = rdata;
            found = 1'b1;
            @(negedge clk);
            mem_read = 1'b0; addr = '0;
          end else begin
            @(negedge clk); n++;
          end
        end
      end
    join
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL coll_timeout: got %b required 1", found); end
    checks++; if (seen !== 32'h3C) begin errors++; $display("FAIL coll_old_byte: got %h required 3c", seen); end
    bus_read(A_CON, d);
    checks++; if (d !== 32'hB) begin errors++; $display("FAIL coll_ready_kept: got %h required b", d); end
    bus_read(A_RXD, d);
    checks++; if (d !== 32'h81) begin errors++; $display("FAIL coll_new_byte: got %h required 81", d); end
    bus_read(A_CON, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL coll_con_after: got %h required 3", d); end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] d;
    int          n;
    bus_write(A_TXD, 32'hA5);
    n = 0;
    while (uart_tx !== 1'b0 && n < 4 * BIT) begin
      @(negedge clk); n++;
    end
    repeat (5 * BIT + BIT / 2) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_bit4: got %b required 0", uart_tx); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b required 1", uart_tx); end
    reset = 1'b0;
    bus_read(A_CON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_con: got %h required 0", d); end
    bus_write(A_TXD, 32'h55);
    check_tx_frame(8'h55, "tx_after_reset");
    repeat (BIT) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq_masked: got %b required 0", irq); end
    bus_read(A_CON, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL mid_con_done: got %h required 4", d); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_div_and_decode();
    test_transmit();
    test_receive();
    test_false_start();
    test_framing();
    test_busy_write();
    test_collision();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
